q2a03_cycle_ctl: RTL and testbench
==================================

Name: q2a03_cycle_ctl

Overview:
- Parametrised timing and interrupt front-end for the Q2A03 CPU family.
- Generates the phi1/phi2 phase and latch strobes from the master clock with a configurable divide ratio.
- Detects NMI edges and arbitrates RESET, NMI and several maskable IRQ sources.
- Presents the CPU core with a break-force flag and a vector address that stay stable for the whole interrupt sequence.

Parameters:
- DIV, 12, master clocks per CPU cycle (>=4).
- PHY2_START, 6, tick value at which phi2 goes high (1..DIV-1).
- IRQ_SRC, 4, number of active-low IRQ inputs (1..8).
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RES, 16'hFFFC, reset vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- G_clock  in  1  master clock.
- G_reset  in  1  synchronous reset, active-high.
- G_ready  in  1  cycle advance enable; low stalls the phase counter.
- G_nmi  in  1  NMI, active-low, falling-edge triggered.
- G_irq  in  IRQ_SRC  IRQ lines, active-low, level.
- irq_mask  in  IRQ_SRC  per-source enable, 1 = enabled.
- i_flag  in  1  CPU P.I bit.
- cpu_sync  in  1  CPU is in cycle 0 (opcode fetch).
- G_phy2  out  1  phi2 phase.
- edge_rise  out  1  one-clock strobe at phi2 rising.
- edge_fall  out  1  one-clock strobe at phi2 falling; this is the CPU state-latch strobe.
- force_brk  out  1  latched: the next sequence is a hardware interrupt.
- vec_addr  out  16  latched vector low-byte address; the high byte is vec_addr+1.
- int_ack  out  1  one-clock pulse when an interrupt is taken.
- int_kind  out  2  kind taken: 0 soft BRK, 1 IRQ, 2 NMI, 3 RESET; valid while int_ack is high, held afterwards.
- irq_pending  out  IRQ_SRC  ~G_irq & irq_mask, registered.
- debug_tick  out  32  debug cycle counter.

Behaviour:
- Reset state (G_reset high at a clock edge):
  - tick=0, phy1=0, last_nmi=1, nmi_p=0, res_p=1.
  - Outputs: G_phy2=0, edge_rise=0, edge_fall=0, force_brk=1, vec_addr=VEC_RES, int_ack=0, int_kind=3, irq_pending=0.
  - Reset mid-sequence aborts the sequence immediately; no strobe is issued in the reset cycle.
- Phase counter:
  - When G_ready=1, tick increments and wraps from DIV-1 to 0. When G_ready=0, tick holds.
  - G_phy2 = (tick >= PHY2_START), combinational from tick.
  - phy1 register <= G_phy2 on every clock with G_ready=1.
- Strobes:
  - edge_rise = G_ready & G_phy2 & ~phy1.
  - edge_fall = G_ready & phy1 & ~G_phy2.
  - Exactly one of each per DIV ready clocks. Both are suppressed while G_reset is high.
- NMI detection:
  - last_nmi <= G_nmi every clock, independent of G_ready, so edges are not lost during stalls.
  - last_nmi & ~G_nmi sets nmi_p.
- IRQ:
  - irq_pending <= ~G_irq & irq_mask every clock.
  - irq_p = |irq_pending & ~i_flag.
- Arbitration (at edge_fall with cpu_sync=1):
  - Priority: res_p > nmi_p > irq_p > soft BRK.
  - Latch vec_addr: VEC_RES / VEC_NMI / VEC_IRQ / VEC_IRQ.
  - Latch force_brk = res_p | nmi_p | irq_p.
  - Latch int_kind = 3 / 2 / 1 / 0.
  - Pulse int_ack for that one clock.
  - Clear the winning pending flag: res_p if RESET won, otherwise nmi_p if NMI won. IRQ is level and is not cleared.
  - Outside this condition vec_addr, force_brk and int_kind hold.
- Simultaneous events:
  - A new NMI falling edge on the same clock nmi_p is cleared leaves nmi_p=1 (set wins), so the second NMI is serviced later.
  - An IRQ masked by i_flag at the latch instant is ignored for that sequence.

Optional Feature:
- Macro: Q2A03_DEBUG_TICK_EN.
- Defined:
  - debug_tick resets to 32'hFFFFFFEB (-21).
  - Adds 3 on each edge_fall.
  - Wraps modulo 2^32.
- Undefined: debug_tick is constant 0 and the counter logic is absent.

Test Plan:
- Reset, hold G_ready=1, DIV=12, PHY2_START=6 -> G_phy2 high on ticks 6..11; edge_rise the clock tick becomes 7 (phy1 still 0); edge_fall every 12 clocks.
- Release reset, cpu_sync=1 at first edge_fall -> int_ack=1, int_kind=3, vec_addr=16'hFFFC; at next sync edge_fall with no sources -> force_brk=0, int_kind=0, vec_addr=16'hFFFE.
- Drive G_nmi 1->0 with G_irq[0]=0, mask=1, i_flag=0, then sync edge_fall -> vec_addr=16'hFFFA, int_kind=2; next sync -> vec_addr=16'hFFFE, int_kind=1.
- G_irq[2]=0 with irq_mask[2]=0, or with i_flag=1 -> no IRQ taken (force_brk=0); irq_pending=4'b0100 only when the mask bit is set.
- Hold G_ready=0 for 30 clocks while G_nmi falls -> tick frozen, no strobes; after ready returns, the NMI is serviced at the next sync edge_fall.
- With Q2A03_DEBUG_TICK_EN defined: after 10 edge_falls debug_tick = 9. Assert G_reset between edges -> strobes suppressed; res_p=1 and debug_tick=-21 on release.

Source files
------------

// File: rtl/q2a03_cycle_ctl_if.sv
// Signal bundle between the Q2A03 cycle controller and the CPU core / interrupt sources.
// The slave modport is the controller side; the master modport is the core/environment side.
interface q2a03_cycle_ctl_if #(
    parameter int unsigned IRQ_SRC = 4
) ();
    logic                G_ready;
    logic                G_nmi;
    logic [IRQ_SRC-1:0]  G_irq;
    logic [IRQ_SRC-1:0]  irq_mask;
    logic                i_flag;
    logic                cpu_sync;
    logic                G_phy2;
    logic                edge_rise;
    logic                edge_fall;
    logic                force_brk;
    logic [15:0]         vec_addr;
    logic                int_ack;
    logic [1:0]          int_kind;
    logic [IRQ_SRC-1:0]  irq_pending;
    logic [31:0]         debug_tick;

    modport slave (
        input  G_ready, G_nmi, G_irq, irq_mask, i_flag, cpu_sync,
        output G_phy2, edge_rise, edge_fall, force_brk, vec_addr, int_ack, int_kind,
        output irq_pending, debug_tick
    );

    modport master (
        output G_ready, G_nmi, G_irq, irq_mask, i_flag, cpu_sync,
        input  G_phy2, edge_rise, edge_fall, force_brk, vec_addr, int_ack, int_kind,
        input  irq_pending, debug_tick
    );
endinterface

// File: rtl/q2a03_cycle_ctl.sv
// Q2A03 cycle controller: phi1/phi2 timing, NMI edge detection and RESET/NMI/IRQ/BRK arbitration.
// Define Q2A03_DEBUG_TICK_EN to enable the debug_tick counter (otherwise it reads constant 0).
module q2a03_cycle_ctl #(
    parameter int unsigned DIV        = 12,
    parameter int unsigned PHY2_START = 6,
    parameter int unsigned IRQ_SRC    = 4,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RES    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input logic              G_clock,
    input logic              G_reset,
    q2a03_cycle_ctl_if.slave bus
);
    localparam int unsigned      TickW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(DIV - 1);
    localparam logic [TickW-1:0] TickPhy2 = TickW'(PHY2_START);

    typedef enum logic [1:0] {
        KindBrk = 2'd0,
        KindIrq = 2'd1,
        KindNmi = 2'd2,
        KindRes = 2'd3
    } int_kind_e;

    logic [TickW-1:0]   tick_q, tick_d;
    logic               phy1_q, phy1_d;
    logic               last_nmi_q;
    logic               nmi_p_q, nmi_p_d;
    logic               res_p_q, res_p_d;
    logic [IRQ_SRC-1:0] irq_pending_q;
    logic               force_brk_q, force_brk_d;
    logic [15:0]        vec_addr_q, vec_addr_d;
    logic               int_ack_q, int_ack_d;
    int_kind_e          int_kind_q, int_kind_d;

    logic               phy2;
    logic               edge_rise;
    logic               edge_fall;
    logic               take;
    logic               irq_p;
    logic               nmi_set;
    int_kind_e          win_kind;
    logic [15:0]        win_vec;

    assign phy2      = (tick_q >= TickPhy2);
    assign edge_rise = bus.G_ready & phy2 & ~phy1_q & ~G_reset;
    assign edge_fall = bus.G_ready & phy1_q & ~phy2 & ~G_reset;
    assign take      = edge_fall & bus.cpu_sync;
    assign irq_p     = (|irq_pending_q) & ~bus.i_flag;
    assign nmi_set   = last_nmi_q & ~bus.G_nmi;

    always_comb begin
        win_kind = KindBrk;
        win_vec  = VEC_IRQ;
        if (res_p_q) begin
            win_kind = KindRes;
            win_vec  = VEC_RES;
        end else if (nmi_p_q) begin
            win_kind = KindNmi;
            win_vec  = VEC_NMI;
        end else if (irq_p) begin
            win_kind = KindIrq;
            win_vec  = VEC_IRQ;
        end
    end

    always_comb begin
        tick_d      = tick_q;
        phy1_d      = phy1_q;
        force_brk_d = force_brk_q;
        vec_addr_d  = vec_addr_q;
        int_kind_d  = int_kind_q;
        int_ack_d   = take;
        if (bus.G_ready) begin
            tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
            phy1_d = phy2;
        end
        if (take) begin
            force_brk_d = (win_kind != KindBrk);
            vec_addr_d  = win_vec;
            int_kind_d  = win_kind;
        end
        res_p_d = res_p_q & ~(take & (win_kind == KindRes));
        // A fresh NMI edge wins over the clear so a back-to-back NMI is not lost.
        nmi_p_d = nmi_set | (nmi_p_q & ~(take & (win_kind == KindNmi)));
    end

    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            tick_q        <= '0;
            phy1_q        <= 1'b0;
            last_nmi_q    <= 1'b1;
            nmi_p_q       <= 1'b0;
            res_p_q       <= 1'b1;
            irq_pending_q <= '0;
            force_brk_q   <= 1'b1;
            vec_addr_q    <= VEC_RES;
            int_ack_q     <= 1'b0;
            int_kind_q    <= KindRes;
        end else begin
            tick_q        <= tick_d;
            phy1_q        <= phy1_d;
            last_nmi_q    <= bus.G_nmi;
            nmi_p_q       <= nmi_p_d;
            res_p_q       <= res_p_d;
            irq_pending_q <= ~bus.G_irq & bus.irq_mask;
            force_brk_q   <= force_brk_d;
            vec_addr_q    <= vec_addr_d;
            int_ack_q     <= int_ack_d;
            int_kind_q    <= int_kind_d;
        end
    end

    assign bus.G_phy2      = phy2;
    assign bus.edge_rise   = edge_rise;
    assign bus.edge_fall   = edge_fall;
    assign bus.force_brk   = force_brk_q;
    assign bus.vec_addr    = vec_addr_q;
    assign bus.int_ack     = int_ack_q;
    assign bus.int_kind    = int_kind_q;
    assign bus.irq_pending = irq_pending_q;

`ifdef Q2A03_DEBUG_TICK_EN
    logic [31:0] dbg_q, dbg_d;

    // Starts at -21 so the count reads small positive values after a few CPU cycles.
    assign dbg_d = edge_fall ? dbg_q + 32'd3 : dbg_q;

    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            dbg_q <= 32'hFFFF_FFEB;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign bus.debug_tick = dbg_q;
`else
    assign bus.debug_tick = '0;
`endif
endmodule

// File: tb/tb_q2a03_cycle_ctl.sv
// Self-checking bench for q2a03_cycle_ctl: directed scenarios followed by randomized stimulus,
// all compared every cycle against a rule-level reference model.
module tb_q2a03_cycle_ctl;
    localparam int unsigned DIV        = 12;
    localparam int unsigned PHY2_START = 6;
    localparam int unsigned IRQ_SRC    = 4;
    localparam logic [15:0] VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] VEC_RES    = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ    = 16'hFFFE;

    logic G_clock = 1'b0;
    logic G_reset;

    q2a03_cycle_ctl_if #(.IRQ_SRC(IRQ_SRC)) bus ();

    q2a03_cycle_ctl #(
        .DIV       (DIV),
        .PHY2_START(PHY2_START),
        .IRQ_SRC   (IRQ_SRC),
        .VEC_NMI   (VEC_NMI),
        .VEC_RES   (VEC_RES),
        .VEC_IRQ   (VEC_IRQ)
    ) dut (
        .G_clock(G_clock),
        .G_reset(G_reset),
        .bus    (bus)
    );

    always #5 G_clock = ~G_clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: cycle position, "has advanced since reset", and the interrupt bookkeeping.
    int                 m_tick;
    bit                 m_adv;
    bit                 m_last_nmi;
    bit                 m_nmi_p;
    bit                 m_res_p;
    bit                 m_fbrk;
    bit                 m_ack;
    logic [IRQ_SRC-1:0] m_pend;
    logic [15:0]        m_vec;
    logic [1:0]         m_kind;
    logic [31:0]        m_dbg;
    int                 m_falls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_phy2();
        return m_tick >= int'(PHY2_START);
    endfunction

    function automatic bit exp_rise();
        return !G_reset && bus.G_ready && (m_tick == int'(PHY2_START));
    endfunction

    function automatic bit exp_fall();
        return !G_reset && bus.G_ready && m_adv && (m_tick == 0);
    endfunction

    task automatic model_reset();
        m_tick     = 0;
        m_adv      = 1'b0;
        m_last_nmi = 1'b1;
        m_nmi_p    = 1'b0;
        m_res_p    = 1'b1;
        m_fbrk     = 1'b1;
        m_ack      = 1'b0;
        m_pend     = '0;
        m_vec      = VEC_RES;
        m_kind     = 2'd3;
        m_falls    = 0;
`ifdef Q2A03_DEBUG_TICK_EN
        m_dbg      = 32'hFFFF_FFEB;
`else
        m_dbg      = 32'd0;
`endif
    endtask

    task automatic model_step();
        bit fall;
        bit take;
        bit irq_p;
        bit nmi_edge;
        if (G_reset) begin
            model_reset();
            return;
        end
        fall     = exp_fall();
        take     = fall && bus.cpu_sync;
        irq_p    = (m_pend != '0) && !bus.i_flag;
        nmi_edge = m_last_nmi && !bus.G_nmi;
        m_ack    = take;
        if (take) begin
            if (m_res_p) begin
                m_kind = 2'd3; m_vec = VEC_RES; m_fbrk = 1'b1; m_res_p = 1'b0;
            end else if (m_nmi_p) begin
                m_kind = 2'd2; m_vec = VEC_NMI; m_fbrk = 1'b1; m_nmi_p = 1'b0;
            end else if (irq_p) begin
                m_kind = 2'd1; m_vec = VEC_IRQ; m_fbrk = 1'b1;
            end else begin
                m_kind = 2'd0; m_vec = VEC_IRQ; m_fbrk = 1'b0;
            end
        end
        if (nmi_edge) m_nmi_p = 1'b1;
        if (bus.G_ready) begin
            m_tick = (m_tick + 1) % int'(DIV);
            m_adv  = 1'b1;
        end
        m_last_nmi = bus.G_nmi;
        m_pend     = ~bus.G_irq & bus.irq_mask;
        if (fall) begin
            m_falls++;
`ifdef Q2A03_DEBUG_TICK_EN
            m_dbg = m_dbg + 32'd3;
`endif
        end
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic run_cycle();
        #1;
        chk("phy2",      32'(bus.G_phy2),      32'(exp_phy2()));
        chk("edge_rise", 32'(bus.edge_rise),   32'(exp_rise()));
        chk("edge_fall", 32'(bus.edge_fall),   32'(exp_fall()));
        chk("force_brk", 32'(bus.force_brk),   32'(m_fbrk));
        chk("vec_addr",  32'(bus.vec_addr),    32'(m_vec));
        chk("int_ack",   32'(bus.int_ack),     32'(m_ack));
        chk("int_kind",  32'(bus.int_kind),    32'(m_kind));
        chk("irq_pend",  32'(bus.irq_pending), 32'(m_pend));
        chk("dbg_tick",  bus.debug_tick,       m_dbg);
        @(posedge G_clock);
        model_step();
        @(negedge G_clock);
    endtask

    task automatic wait_ack(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            run_cycle();
            got = m_ack;
        end
        n_cmp++;
        assert (got) else begin
            n_mis++;
            $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
        end
    endtask

    task automatic chk_take(input string tag, input logic [1:0] kind, input logic [15:0] vec,
                            input bit fbrk);
        chk({tag, "_ack"},  32'(bus.int_ack),   32'd1);
        chk({tag, "_kind"}, 32'(bus.int_kind),  32'(kind));
        chk({tag, "_vec"},  32'(bus.vec_addr),  32'(vec));
        chk({tag, "_brk"},  32'(bus.force_brk), 32'(fbrk));
    endtask

    initial begin
        int strobes;
        bit got;
        G_reset      = 1'b1;
        bus.G_ready  = 1'b1;
        bus.G_nmi    = 1'b1;
        bus.G_irq    = '1;
        bus.irq_mask = '0;
        bus.i_flag   = 1'b1;
        bus.cpu_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge G_clock);
        @(negedge G_clock);
        run_cycle();

        // Reset state
        chk("rst_brk",  32'(bus.force_brk),   32'd1);
        chk("rst_vec",  32'(bus.vec_addr),    32'hFFFC);
        chk("rst_kind", 32'(bus.int_kind),    32'd3);
        chk("rst_ack",  32'(bus.int_ack),     32'd0);
        chk("rst_pend", 32'(bus.irq_pending), 32'd0);
        chk("rst_phy2", 32'(bus.G_phy2),      32'd0);

        // First sync sequence takes RESET, the next one is a soft BRK
        G_reset      = 1'b0;
        bus.cpu_sync = 1'b1;
        wait_ack("reset_take");
        chk_take("reset_take", 2'd3, 16'hFFFC, 1'b1);
        wait_ack("brk_take");
        chk_take("brk_take", 2'd0, 16'hFFFE, 1'b0);

        // NMI beats a simultaneously pending IRQ; the IRQ follows
        bus.G_nmi    = 1'b0;
        bus.G_irq    = 4'b1110;
        bus.irq_mask = 4'b0001;
        bus.i_flag   = 1'b0;
        wait_ack("nmi_take");
        chk_take("nmi_take", 2'd2, 16'hFFFA, 1'b1);
        wait_ack("irq_take");
        chk_take("irq_take", 2'd1, 16'hFFFE, 1'b1);

        // Masked source, then I flag set: neither is taken
        bus.G_nmi    = 1'b1;
        bus.G_irq    = 4'b1011;
        bus.irq_mask = 4'b1011;
        wait_ack("mask_take");
        chk_take("mask_take", 2'd0, 16'hFFFE, 1'b0);
        chk("mask_pend", 32'(bus.irq_pending), 32'd0);
        bus.irq_mask = 4'b1111;
        bus.i_flag   = 1'b1;
        wait_ack("iflag_take");
        chk_take("iflag_take", 2'd0, 16'hFFFE, 1'b0);
        chk("iflag_pend", 32'(bus.irq_pending), 32'b0100);
        bus.G_irq  = '1;
        bus.i_flag = 1'b0;

        // Stall with an NMI edge inside it
        run_cycle();
        run_cycle();
        bus.G_ready = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) bus.G_nmi = 1'b0;
            run_cycle();
            strobes += int'(bus.edge_rise) + int'(bus.edge_fall);
        end
        chk("stall_strobes", 32'(strobes), 32'd0);
        bus.G_ready = 1'b1;
        wait_ack("stall_nmi");
        chk_take("stall_nmi", 2'd2, 16'hFFFA, 1'b1);
        bus.G_nmi = 1'b1;

        // Reset between edges, then count ten edge_falls
        bus.cpu_sync = 1'b0;
        repeat (5) run_cycle();
        G_reset = 1'b1;
        repeat (2) run_cycle();
        G_reset = 1'b0;
        chk("mid_rst_vec",  32'(bus.vec_addr),  32'hFFFC);
        chk("mid_rst_brk",  32'(bus.force_brk), 32'd1);
        chk("mid_rst_kind", 32'(bus.int_kind),  32'd3);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            run_cycle();
            got = (m_falls == 10);
        end
        n_cmp++;
        assert (got) else begin
            n_mis++;
            $error("FAIL falls10_timeout observed=%0d expected=10", m_falls);
        end
`ifdef Q2A03_DEBUG_TICK_EN
        chk("dbg_after10", bus.debug_tick, 32'd9);
`else
        chk("dbg_after10", bus.debug_tick, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            G_reset     = ($urandom_range(0, 299) == 0);
            bus.G_ready = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.G_nmi = ~bus.G_nmi;
            if ($urandom_range(0, 7) == 0) bus.G_irq = IRQ_SRC'($urandom);
            if ($urandom_range(0, 31) == 0) bus.irq_mask = IRQ_SRC'($urandom);
            if ($urandom_range(0, 15) == 0) bus.i_flag = ~bus.i_flag;
            bus.cpu_sync = ($urandom_range(0, 1) == 1);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
